// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with an in-order prefetch queue. Requests allocate queue
// entries, responses fill them in order, and redirects flush the queue and drop stale responses.
module ifu_prefetch #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    ILEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [XLEN-1:0]            req_addr_o,
  input  logic                       rsp_valid_i,
  input  logic [ILEN-1:0]            rsp_data_i,
  input  logic                       rsp_err_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [ILEN-1:0]            inst_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       inst_err_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [ILEN-1:0]  inst_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] filled_q;

  ptr_t            wr_ptr;
  ptr_t            fill_ptr;
  ptr_t            rd_ptr;
  cnt_t            count;
  cnt_t            pend_cnt;
  cnt_t            drop_cnt;
  logic [XLEN-1:0] fetch_pc;

  logic req_hs;
  logic rsp_drop;
  logic rsp_fill;
  logic pop;
  cnt_t inflight;
  cnt_t redirect_drop;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Every allocated entry or dropped response holds one slot of the DEPTH budget.
  assign inflight    = count + drop_cnt;
  assign req_valid_o = rst_i & (inflight < DEPTH_C);
  assign req_addr_o  = fetch_pc;
  assign req_hs      = req_valid_o & req_ready_i;

  assign rsp_drop = rsp_valid_i & (drop_cnt != '0);
  assign rsp_fill = rsp_valid_i & (drop_cnt == '0) & (pend_cnt != '0);

  assign inst_valid_o = (count != '0) & filled_q[rd_ptr];
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = inst_valid_o ? inst_q[rd_ptr] : '0;
  assign pc_o         = inst_valid_o ? pc_q[rd_ptr]   : '0;
  assign inst_err_o   = inst_valid_o & err_q[rd_ptr];
  assign occupancy_o  = count;

  // Everything still owed by memory after a flush must be discarded on arrival.
  assign redirect_drop = drop_cnt + pend_cnt + cnt_t'(req_hs) - cnt_t'(rsp_drop | rsp_fill);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q     <= '{default: '0};
      inst_q   <= '{default: '0};
      err_q    <= '0;
      filled_q <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc_q     <= '{default: '0};
      inst_q   <= '{default: '0};
      err_q    <= '0;
      filled_q <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= redirect_drop;
      fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
    end else begin
      if (req_hs) begin
        pc_q[wr_ptr]     <= fetch_pc;
        filled_q[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + 1'b1;
        fetch_pc         <= fetch_pc + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (rsp_fill) begin
        inst_q[fill_ptr]   <= rsp_data_i;
        err_q[fill_ptr]    <= rsp_err_i;
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + 1'b1;
      end
      // Fill targets an unfilled entry and pop a filled one, so their indices never collide.
      if (pop) begin
        pc_q[rd_ptr]     <= '0;
        inst_q[rd_ptr]   <= '0;
        err_q[rd_ptr]    <= 1'b0;
        filled_q[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      count    <= count + cnt_t'(req_hs) - cnt_t'(pop);
      pend_cnt <= pend_cnt + cnt_t'(req_hs) - cnt_t'(rsp_fill);
    end
  end

  // A response with nothing outstanding is a memory protocol error and is ignored.
  assert property (@(posedge clk_i) disable iff (!rst_i)
    rsp_valid_i |-> ((drop_cnt != '0) || (pend_cnt != '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: an in-order memory with random latency, an epoch-based
// reference model of which fetches survive redirects, and a scoreboard checked at each pop.
module tb_ifu_prefetch;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH+1);
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            req_valid_o;
  logic            req_ready_i;
  logic [XLEN-1:0] req_addr_o;
  logic            rsp_valid_i;
  logic [ILEN-1:0] rsp_data_i;
  logic            rsp_err_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;
  logic            inst_err_o;
  logic [CW-1:0]   occupancy_o;

  ifu_prefetch #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .pc_o(pc_o), .inst_err_o(inst_err_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
    int          epoch;
    int          due;
  } txn_t;

  txn_t mem_q[$];
  txn_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_epoch = 0;
  int          live_pend = 0;
  int          live_filled = 0;
  logic [31:0] model_pc = RESET_PC;
  bit          rst_seen = 0;
  bit          prev_rst = 0;

  int          ready_pct = 100;
  int          req_rdy_pct = 100;
  int          redir_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          hold_reset = 1;
  bit          force_redir = 0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[7:2] == 6'd2;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares outputs against the model and pops the scoreboard on every delivery.
  always @(negedge clk_i) begin
    txn_t t;
    if (!rst_i) begin
      check_output("reset_req_valid", req_valid_o, 0);
      if (prev_rst) begin
        check_output("reset_occupancy", occupancy_o, 0);
        check_output("reset_inst_valid", inst_valid_o, 0);
        check_output("reset_inst", inst_o, 0);
        check_output("reset_pc", pc_o, 0);
        check_output("reset_err", inst_err_o, 0);
      end
    end else if (rst_seen) begin
      check_output("req_valid", req_valid_o, (mem_q.size() + live_filled) < DEPTH);
      if (req_valid_o) check_output("req_addr", req_addr_o, model_pc);
      check_output("occupancy", occupancy_o, live_pend + live_filled);
      check_output("inst_valid", inst_valid_o, live_filled > 0);
      if (inst_valid_o && inst_ready_i && !redirect_valid_i) begin
        while (exp_q.size() > 0 && exp_q[0].epoch != cur_epoch) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty: got delivery pc 0x%0h, expected none (cycle %0d)", pc_o, cyc);
        end else begin
          t = exp_q.pop_front();
          check_output("deliver_pc", pc_o, t.addr);
          check_output("deliver_inst", inst_o, t.inst);
          check_output("deliver_err", inst_err_o, t.err);
        end
      end
    end
  end

  task automatic step_cycle();
    logic        s_rst, s_hs, s_rsp, s_pop, s_redir;
    logic [31:0] s_rpc, s_addr;
    txn_t        r, n, e;
    @(negedge clk_i);
    s_rst   = rst_i;
    s_hs    = req_valid_o && req_ready_i;
    s_addr  = req_addr_o;
    s_rsp   = rsp_valid_i;
    s_pop   = inst_valid_o && inst_ready_i;
    s_redir = redirect_valid_i;
    s_rpc   = redirect_pc_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (!s_rst) begin
      mem_q.delete();
      exp_q.delete();
      cur_epoch++;
      live_pend   = 0;
      live_filled = 0;
      model_pc    = RESET_PC;
      rst_seen    = 1;
      prev_rst    = 1;
      return;
    end
    prev_rst = 0;
    if (s_rsp && mem_q.size() > 0) begin
      r = mem_q.pop_front();
      if (!s_redir && r.epoch == cur_epoch) begin
        live_pend--;
        live_filled++;
      end
    end
    if (s_hs) begin
      n.addr  = s_addr;
      n.inst  = mem_inst(s_addr);
      n.err   = mem_err(s_addr);
      n.epoch = cur_epoch;
      n.due   = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
      mem_q.push_back(n);
      e       = n;
      e.addr  = model_pc;
      e.inst  = mem_inst(model_pc);
      e.err   = mem_err(model_pc);
      exp_q.push_back(e);
      if (!s_redir) begin
        live_pend++;
        model_pc = model_pc + 32'd4;
      end
    end
    if (s_redir) begin
      cur_epoch++;
      live_pend   = 0;
      live_filled = 0;
      model_pc    = {s_rpc[31:2], 2'b00};
    end else if (s_pop && live_filled > 0) begin
      live_filled--;
    end
  endtask

  task automatic apply_stimulus(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      rst_i            = !hold_reset;
      inst_ready_i     = ($urandom_range(99, 0) < ready_pct);
      req_ready_i      = ($urandom_range(99, 0) < req_rdy_pct);
      redirect_valid_i = 1'b0;
      redirect_pc_i    = $urandom;
      rsp_valid_i      = 1'b0;
      rsp_data_i       = $urandom;
      rsp_err_i        = 1'($urandom_range(1, 0));
      if (rst_i) begin
        if (force_redir) begin
          redirect_valid_i = 1'b1;
          redirect_pc_i    = force_pc;
          force_redir      = 0;
        end else if ($urandom_range(99, 0) < redir_pct) begin
          redirect_valid_i = 1'b1;
          if ($urandom_range(3, 0) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
          else redirect_pc_i = 32'h8000_1000 + 32'($urandom_range(255, 0));
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
          rsp_valid_i = 1'b1;
          rsp_data_i  = mem_q[0].inst;
          rsp_err_i   = mem_q[0].err;
        end
      end
      step_cycle();
    end
  endtask

  task automatic do_reset();
    hold_reset = 1;
    apply_stimulus(2);
    hold_reset = 0;
  endtask

  initial begin
    rst_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_err_i = 1'b0; inst_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset();

    $display("[TB] sequential fetch with 1-cycle memory");
    apply_stimulus(20);

    $display("[TB] decoder stall fills the queue, then drains");
    do_reset();
    ready_pct = 0;
    apply_stimulus(12);
    ready_pct = 100;
    apply_stimulus(12);

    $display("[TB] redirect with three requests outstanding at 5-cycle latency");
    do_reset();
    lat_min = 5; lat_max = 5;
    apply_stimulus(3);
    req_rdy_pct = 0; force_redir = 1; force_pc = 32'h8000_1002;
    apply_stimulus(1);
    req_rdy_pct = 100;
    apply_stimulus(25);

    $display("[TB] redirect coinciding with handshake and response");
    do_reset();
    lat_min = 1; lat_max = 1;
    apply_stimulus(6);
    force_redir = 1; force_pc = 32'h8000_2000;
    apply_stimulus(15);

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 20; seg++) begin
      ready_pct   = $urandom_range(100, 20);
      req_rdy_pct = $urandom_range(100, 30);
      redir_pct   = $urandom_range(8, 0);
      lat_min     = $urandom_range(3, 1);
      lat_max     = lat_min + $urandom_range(5, 0);
      apply_stimulus(100);
    end

    $display("[TB] reset with a full queue");
    redir_pct = 0; ready_pct = 0; req_rdy_pct = 100; lat_min = 1; lat_max = 3;
    apply_stimulus(15);
    do_reset();
    ready_pct = 100;
    apply_stimulus(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
